// File: rtl/idu_decode_stage.sv
// Registered RV32 instruction-decode stage with a two-entry skid buffer.
// Upstream ready is a pure decode of buffer occupancy; downstream stalls never reach it combinationally.
module idu_decode_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [6:0]       out_opcode,
  output logic [4:0]       out_rd,
  output logic [2:0]       out_funct3,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [6:0]       out_funct7,
  output logic [XLEN-1:0]  out_imm,
  output logic [XLEN-1:0]  out_csr_imm,
  output logic             out_inv,
  output logic             out_ebreak,
  output logic             out_ecall,
  output logic [CNT_W-1:0] decoded_cnt,
  output logic [1:0]       dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both high.
  // While out_valid=1 and out_ready=0 the head payload is held unchanged.
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] csr_imm;
    logic            inv;
    logic            ebreak;
    logic            ecall;
  } entry_t;

  state_e      state_q, state_d;
  entry_t      head_q, head_d, tail_q, tail_d;
  entry_t      dec;
  logic [31:0] imm32;
  logic        in_fire, out_fire;

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign dbg_state = state_q;

  always_comb begin
    imm32       = '0;
    dec         = '0;
    dec.pc      = in_pc;
    dec.inst    = in_inst;
    case (in_inst[6:0])
      7'b0110111, 7'b0010111: imm32 = {in_inst[31:12], 12'b0};
      7'b1101111: imm32 = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
      7'b0010011, 7'b1100111, 7'b0000011: imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
      7'b0100011: imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      7'b1100011: imm32 = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
      7'b0110011, 7'b1110011: imm32 = '0;
      default: dec.inv = 1'b1;
    endcase
    dec.imm     = XLEN'($signed(imm32));
    dec.csr_imm = XLEN'($signed(in_inst[31:20]));
    dec.ebreak  = (in_inst == 32'h0010_0073);
    dec.ecall   = (in_inst == 32'h0000_0073);
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (in_fire) begin
          head_d  = dec;
          state_d = ONE;
        end
        ONE: begin
          if (in_fire && out_fire) begin
            head_d = dec;
          end else if (in_fire) begin
            tail_d  = dec;
            state_d = TWO;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        TWO: if (out_fire) begin
          head_d  = tail_q;
          state_d = ONE;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // An out_fire coincident with flush was already consumed downstream, so it counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) decoded_cnt <= '0;
    else if (out_fire) decoded_cnt <= decoded_cnt + CNT_W'(1);
  end

  assign out_pc      = head_q.pc;
  assign out_opcode  = head_q.inst[6:0];
  assign out_rd      = head_q.inst[11:7];
  assign out_funct3  = head_q.inst[14:12];
  assign out_rs1     = head_q.inst[19:15];
  assign out_rs2     = head_q.inst[24:20];
  assign out_funct7  = head_q.inst[31:25];
  assign out_imm     = head_q.imm;
  assign out_csr_imm = head_q.csr_imm;
  assign out_inv     = head_q.inv;
  assign out_ebreak  = head_q.ebreak;
  assign out_ecall   = head_q.ecall;

endmodule

// File: tb/tb_idu_decode_stage.sv
// Bench for idu_decode_stage: queue scoreboard fed by the driver, checked by an output monitor,
// plus a 64-bit / 4-bit-counter instance for sign extension and counter wrap.
module tb_idu_decode_stage;

  localparam int EW = 32 + 32 + 32 + 32 + 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_inst = '0, in_pc = '0;
  logic        in_ready, out_valid, out_inv, out_ebreak, out_ecall;
  logic [31:0] out_pc, out_imm, out_csr_imm, decoded_cnt;
  logic [6:0]  out_opcode, out_funct7;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [2:0]  out_funct3;
  logic [1:0]  dbg_state;

  logic        w_flush = 1'b0, w_in_valid = 1'b0, w_out_ready = 1'b0;
  logic [31:0] w_in_inst = '0;
  logic [63:0] w_in_pc = '0;
  logic        w_in_ready, w_out_valid, w_out_inv, w_out_ebreak, w_out_ecall;
  logic [63:0] w_out_pc, w_out_imm, w_out_csr_imm;
  logic [6:0]  w_out_opcode, w_out_funct7;
  logic [4:0]  w_out_rd, w_out_rs1, w_out_rs2;
  logic [2:0]  w_out_funct3;
  logic [3:0]  w_decoded_cnt;
  logic [1:0]  w_dbg_state;

  logic [EW-1:0] exp_q[$];
  logic [31:0]   cnt_exp = '0;
  int            n_cmp = 0, n_bad = 0;
  logic          stall_prev = 1'b0;
  logic [31:0]   held_pc, held_imm;
  logic [6:0]    ops [10] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b0010011, 7'b1100111,
                              7'b0000011, 7'b0100011, 7'b1100011, 7'b0110011, 7'b1110011};

  idu_decode_stage #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_opcode(out_opcode), .out_rd(out_rd), .out_funct3(out_funct3),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct7(out_funct7), .out_imm(out_imm),
    .out_csr_imm(out_csr_imm), .out_inv(out_inv), .out_ebreak(out_ebreak),
    .out_ecall(out_ecall), .decoded_cnt(decoded_cnt), .dbg_state(dbg_state)
  );

  idu_decode_stage #(.XLEN(64), .CNT_W(4)) dut_w (
    .clk(clk), .rst(rst), .flush(w_flush), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_inst(w_in_inst), .in_pc(w_in_pc), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_pc(w_out_pc), .out_opcode(w_out_opcode), .out_rd(w_out_rd), .out_funct3(w_out_funct3),
    .out_rs1(w_out_rs1), .out_rs2(w_out_rs2), .out_funct7(w_out_funct7), .out_imm(w_out_imm),
    .out_csr_imm(w_out_csr_imm), .out_inv(w_out_inv), .out_ebreak(w_out_ebreak),
    .out_ecall(w_out_ecall), .decoded_cnt(w_decoded_cnt), .dbg_state(w_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial forever #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] sra(logic [31:0] x, int n);
    logic signed [31:0] s;
    s = x;
    return s >>> n;
  endfunction

  function automatic logic [EW-1:0] model(logic [31:0] inst, logic [31:0] pc);
    logic [31:0] imm;
    logic        inv;
    imm = '0;
    inv = 1'b0;
    case (inst[6:0])
      7'b0110111, 7'b0010111: imm = inst & 32'hFFFF_F000;
      7'b0010011, 7'b1100111, 7'b0000011: imm = sra(inst, 20);
      7'b0100011: imm = (sra(inst, 25) << 5) | 32'(inst[11:7]);
      7'b1100011: imm = (sra(inst, 31) << 12) | (32'(inst[7]) << 11)
                        | (32'(inst[30:25]) << 5) | (32'(inst[11:8]) << 1);
      7'b1101111: imm = (sra(inst, 31) << 20) | (32'(inst[19:12]) << 12)
                        | (32'(inst[20]) << 11) | (32'(inst[30:21]) << 1);
      7'b0110011, 7'b1110011: imm = '0;
      default: inv = 1'b1;
    endcase
    return {pc, inst, imm, sra(inst, 20), inv, inst == 32'h0010_0073, inst == 32'h0000_0073};
  endfunction

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- output monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [31:0]   e_inst;
    if (!rst) begin
      check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      check("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
      check("dbg_state", 64'(dbg_state), 64'(exp_q.size()));
      check("decoded_cnt", 64'(decoded_cnt), 64'(cnt_exp));
      if (stall_prev && out_valid) begin
        check("stall_pc", 64'(out_pc), 64'(held_pc));
        check("stall_imm", 64'(out_imm), 64'(held_imm));
      end
      stall_prev = out_valid && !out_ready && !flush;
      held_pc    = out_pc;
      held_imm   = out_imm;
      if (out_valid && out_ready && exp_q.size() != 0) begin
        e      = exp_q.pop_front();
        e_inst = e[98:67];
        check("pc", 64'(out_pc), 64'(e[130:99]));
        check("opcode", 64'(out_opcode), 64'(e_inst[6:0]));
        check("rd", 64'(out_rd), 64'(e_inst[11:7]));
        check("funct3", 64'(out_funct3), 64'(e_inst[14:12]));
        check("rs1", 64'(out_rs1), 64'(e_inst[19:15]));
        check("rs2", 64'(out_rs2), 64'(e_inst[24:20]));
        check("funct7", 64'(out_funct7), 64'(e_inst[31:25]));
        check("imm", 64'(out_imm), 64'(e[66:35]));
        check("csr_imm", 64'(out_csr_imm), 64'(e[34:3]));
        check("inv", 64'(out_inv), 64'(e[2]));
        check("ebreak", 64'(out_ebreak), 64'(e[1]));
        check("ecall", 64'(out_ecall), 64'(e[0]));
        cnt_exp = cnt_exp + 1;
      end
      if (flush) exp_q.delete();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                      input logic ordy, input logic fl, output logic fired);
    in_valid  = v;
    in_inst   = inst;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    #1;
    fired = v && in_ready && !fl;
    if (fired) exp_q.push_back(model(inst, pc));
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] inst, input logic [31:0] pc, input logic ordy);
    logic fired;
    for (int k = 0; k < 50; k++) begin
      step(1'b1, inst, pc, ordy, 1'b0, fired);
      if (fired) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL send_timeout: inst %h never accepted", inst);
  endtask

  task automatic idle(input int n, input logic ordy);
    logic fired;
    for (int k = 0; k < n; k++) step(1'b0, 32'h0, 32'h0, ordy, 1'b0, fired);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    int          k;
    r = $urandom();
    k = $urandom_range(0, 13);
    if (k < 10) r[6:0] = ops[k];
    else if (k == 10) r = 32'h0000_0073;
    else if (k == 11) r = 32'h0010_0073;
    return r;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic        fired;
    logic [31:0] pc;
    int          fires;
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_in_ready", 64'(in_ready), 64'h1);
    check("rst_out_pc", 64'(out_pc), 64'h0);
    check("rst_out_imm", 64'(out_imm), 64'h0);
    check("rst_out_inv", 64'(out_inv), 64'h0);
    check("rst_ebreak_ecall", 64'({out_ebreak, out_ecall}), 64'h0);
    check("rst_cnt", 64'(decoded_cnt), 64'h0);
    check("rst_w_cnt", 64'(w_decoded_cnt), 64'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // single addi, then an lui/jal/beq stream
    send(32'hFFF0_0093, 32'h8000_0000, 1'b1);
    idle(2, 1'b1);
    send(32'h1234_5037, 32'h8000_0004, 1'b1);
    send(32'h0080_006F, 32'h8000_0008, 1'b1);
    send(32'hFE00_0EE3, 32'h8000_000C, 1'b1);
    idle(2, 1'b1);

    // back-pressure: two accepted, third held until downstream drains
    send(32'h0010_0113, 32'h100, 1'b0);
    send(32'h0020_0193, 32'h104, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, 32'h0030_0213, 32'h108, 1'b0, 1'b0, fired);
    send(32'h0030_0213, 32'h108, 1'b1);
    idle(3, 1'b1);

    // illegal, ebreak, ecall, csrrw
    send(32'h0000_0000, 32'h200, 1'b1);
    send(32'h0010_0073, 32'h204, 1'b1);
    send(32'h0000_0073, 32'h208, 1'b1);
    send(32'h3052_9073, 32'h20C, 1'b1);
    idle(2, 1'b1);

    // flush from TWO with a coincident out_fire, then flush dropping a coincident in_fire
    send(32'h0000_0013, 32'h300, 1'b0);
    send(32'h0000_0013, 32'h304, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, fired);
    idle(1, 1'b1);
    send(32'h0050_0293, 32'h308, 1'b0);
    step(1'b1, 32'h0060_0313, 32'h30C, 1'b0, 1'b1, fired);
    idle(2, 1'b1);

    // asynchronous reset mid-stream
    send(32'h0070_0393, 32'h400, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_out_valid", 64'(out_valid), 64'h0);
    check("async_rst_in_ready", 64'(in_ready), 64'h1);
    check("async_rst_cnt", 64'(decoded_cnt), 64'h0);
    exp_q.delete();
    cnt_exp    = '0;
    stall_prev = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    idle(1, 1'b1);

    // randomized traffic
    pc = 32'h1000;
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 3) != 0, rand_inst(), pc, $urandom_range(0, 2) != 0,
           $urandom_range(0, 29) == 0, fired);
      pc = pc + 4;
    end
    idle(4, 1'b1);
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // 64-bit instance: sign extension to bit 63 and a 4-bit counter wrap
    w_in_valid  = 1'b1;
    w_in_inst   = 32'hFFF0_0093;
    w_in_pc     = 64'hFFFF_FFFF_8000_0004;
    w_out_ready = 1'b0;
    @(posedge clk);
    #1 w_in_valid = 1'b0;
    @(negedge clk);
    check("w_out_valid", 64'(w_out_valid), 64'h1);
    check("w_imm", w_out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    check("w_csr_imm", w_out_csr_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    check("w_pc", w_out_pc, 64'hFFFF_FFFF_8000_0004);
    check("w_rd", 64'(w_out_rd), 64'h1);
    @(posedge clk);
    #1;
    w_in_valid  = 1'b1;
    w_out_ready = 1'b1;
    fires = 0;
    for (int k = 0; k < 40 && fires < 17; k++) begin
      @(negedge clk);
      if (w_out_valid && w_out_ready) fires++;
      @(posedge clk);
      #1;
    end
    w_in_valid  = 1'b0;
    w_out_ready = 1'b0;
    check("w_fire_count", 64'(fires), 64'd17);
    @(negedge clk);
    check("w_cnt_wrap", 64'(w_decoded_cnt), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
